// File: rtl/st506_drive_emulator.sv
// Drive-side ST-506 control-cable emulator: decodes select/step/head/write-gate from the host
// and produces seek-complete, track-00, index, ready and write-fault plus geometry state.
module st506_drive_emulator #(
    parameter int unsigned DRIVE_ID      = 0,
    parameter int unsigned NUM_HEADS     = 4,
    parameter int unsigned MAX_CYL       = 1023,
    parameter int unsigned SPINUP_CYCLES = 30000000,
    parameter int unsigned SETTLE_CYCLES = 900000,
    parameter int unsigned INDEX_PERIOD  = 5000000,
    parameter int unsigned INDEX_WIDTH   = 600
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        spin_enable,
    input  logic        fault_clear,
    input  logic [3:0]  st506_drv_sel_n,
    input  logic [3:0]  st506_head_sel_n,
    input  logic        st506_step_n,
    input  logic        st506_dir_n,
    input  logic        st506_write_gate_n,
    output logic        st506_seek_complete_n,
    output logic        st506_track00_n,
    output logic        st506_write_fault_n,
    output logic        st506_index_n,
    output logic        st506_ready_n,
    output logic        selected,
    output logic [9:0]  cylinder,
    output logic [3:0]  head,
    output logic        write_active
);

    localparam int unsigned CYL_W    = 10;
    localparam int unsigned SPIN_W   = $clog2(SPINUP_CYCLES + 1);
    localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned IDX_W    = $clog2(INDEX_PERIOD + 1);
    localparam logic [1:0]  DRV_IDX  = 2'(DRIVE_ID);

    typedef enum logic [1:0] {ST_OFF, ST_SPINUP, ST_READY, ST_SEEKING} state_t;

    state_t              state_q, state_nxt;
    logic [SPIN_W-1:0]   spin_cnt_q, spin_cnt_nxt;
    logic [SETTLE_W-1:0] settle_q, settle_nxt;
    logic [IDX_W-1:0]    idx_q, idx_nxt;
    logic [CYL_W-1:0]    cyl_q, cyl_nxt;
    logic                fault_q;

    logic [3:0] drv_s1, drv_s2, head_s1, head_s2;
    logic       step_s1, step_s2, step_s3;
    logic       dir_s1, dir_s2, wg_s1, wg_s2;

    // Two-flop synchronisers; idle levels are the inactive-high cable levels
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drv_s1  <= 4'hF;  drv_s2  <= 4'hF;
            head_s1 <= 4'hF;  head_s2 <= 4'hF;
            step_s1 <= 1'b1;  step_s2 <= 1'b1;  step_s3 <= 1'b1;
            dir_s1  <= 1'b1;  dir_s2  <= 1'b1;
            wg_s1   <= 1'b1;  wg_s2   <= 1'b1;
        end else begin
            drv_s1  <= st506_drv_sel_n;    drv_s2  <= drv_s1;
            head_s1 <= st506_head_sel_n;   head_s2 <= head_s1;
            step_s1 <= st506_step_n;       step_s2 <= step_s1;  step_s3 <= step_s2;
            dir_s1  <= st506_dir_n;        dir_s2  <= dir_s1;
            wg_s1   <= st506_write_gate_n; wg_s2   <= wg_s1;
        end
    end

    logic       sel, step_rise, dir_in, wg, head_bad, spinning, ready_st, step_acc, fault_set;
    logic [3:0] head_cur;

    assign sel       = ~drv_s2[DRV_IDX];
    assign head_cur  = ~head_s2;
    assign step_rise = step_s2 & ~step_s3;
    assign dir_in    = ~dir_s2;
    assign wg        = ~wg_s2;
    assign head_bad  = {1'b0, head_cur} >= 5'(NUM_HEADS);
    assign spinning  = (state_q != ST_OFF);
    assign ready_st  = (state_q == ST_READY) || (state_q == ST_SEEKING);
    assign step_acc  = step_rise & sel & ready_st & spin_enable;
    assign fault_set = sel & wg & ((state_q != ST_READY) | step_rise | head_bad);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_OFF;
            spin_cnt_q <= '0;
            settle_q   <= '0;
            idx_q      <= '0;
            cyl_q      <= '0;
        end else begin
            state_q    <= state_nxt;
            spin_cnt_q <= spin_cnt_nxt;
            settle_q   <= settle_nxt;
            idx_q      <= idx_nxt;
            cyl_q      <= cyl_nxt;
        end
    end

    // Next-state and counter logic; spindle power loss overrides everything
    always_comb begin
        state_nxt    = state_q;
        spin_cnt_nxt = '0;
        settle_nxt   = settle_q;
        idx_nxt      = '0;
        cyl_nxt      = cyl_q;

        case (state_q)
            ST_OFF:     if (spin_enable) state_nxt = ST_SPINUP;
            ST_SPINUP: begin
                spin_cnt_nxt = spin_cnt_q + SPIN_W'(1);
                if (spin_cnt_q == SPIN_W'(SPINUP_CYCLES - 1)) state_nxt = ST_READY;
            end
            ST_READY:   if (step_acc) state_nxt = ST_SEEKING;
            ST_SEEKING: if (!step_acc && settle_q == '0) state_nxt = ST_READY;
            default:    state_nxt = ST_OFF;
        endcase

        if (step_acc) begin
            settle_nxt = SETTLE_W'(SETTLE_CYCLES - 1);
            if (dir_in) begin
                if (cyl_q != CYL_W'(MAX_CYL)) cyl_nxt = cyl_q + CYL_W'(1);
            end else begin
                if (cyl_q != '0) cyl_nxt = cyl_q - CYL_W'(1);
            end
        end else if (state_q == ST_SEEKING && settle_q != '0) begin
            settle_nxt = settle_q - SETTLE_W'(1);
        end

        if (spinning) idx_nxt = (idx_q == IDX_W'(INDEX_PERIOD - 1)) ? '0 : idx_q + IDX_W'(1);

        if (!spin_enable) begin
            state_nxt    = ST_OFF;
            spin_cnt_nxt = '0;
            settle_nxt   = '0;
            idx_nxt      = '0;
        end
    end

    // Latched write fault; a coincident set condition beats the clear pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)         fault_q <= 1'b0;
        else if (fault_set)   fault_q <= 1'b1;
        else if (fault_clear) fault_q <= 1'b0;
    end

    // Cable outputs are released (driven high) whenever this drive is not selected
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st506_seek_complete_n <= 1'b1;
            st506_track00_n       <= 1'b1;
            st506_write_fault_n   <= 1'b1;
            st506_index_n         <= 1'b1;
            st506_ready_n         <= 1'b1;
            selected              <= 1'b0;
            cylinder              <= '0;
            head                  <= '0;
            write_active          <= 1'b0;
        end else begin
            st506_seek_complete_n <= ~(sel & (state_q == ST_READY));
            st506_track00_n       <= ~(sel & ready_st & (cyl_q == '0));
            st506_write_fault_n   <= ~(sel & fault_q);
            st506_index_n         <= ~(sel & spinning & (idx_q < IDX_W'(INDEX_WIDTH)));
            st506_ready_n         <= ~(sel & ready_st);
            selected              <= sel;
            cylinder              <= cyl_q;
            head                  <= head_cur;
            write_active          <= sel & wg & (state_q == ST_READY) & ~fault_q;
        end
    end

endmodule

// File: tb/tb_st506_drive_emulator.sv
// Self-checking bench for st506_drive_emulator with short timing parameters and MAX_CYL=7.
module tb_st506_drive_emulator;

    localparam int unsigned SPINUP  = 100;
    localparam int unsigned SETTLE  = 50;
    localparam int unsigned PERIOD  = 200;
    localparam int unsigned WIDTH   = 10;
    localparam int unsigned MAXC    = 7;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       spin_enable = 1'b0;
    logic       fault_clear = 1'b0;
    logic [3:0] drv_sel_n = 4'b1101;
    logic [3:0] head_sel_n = 4'b1111;
    logic       step_n = 1'b1;
    logic       dir_n = 1'b1;
    logic       write_gate_n = 1'b1;
    logic       seek_complete_n, track00_n, write_fault_n, index_n, ready_n;
    logic       selected, write_active;
    logic [9:0] cylinder;
    logic [3:0] head;

    int errors = 0;
    int checks = 0;
    int exp_cyl = 0;
    int exp_q[$];

    st506_drive_emulator #(
        .DRIVE_ID(1), .NUM_HEADS(4), .MAX_CYL(MAXC), .SPINUP_CYCLES(SPINUP),
        .SETTLE_CYCLES(SETTLE), .INDEX_PERIOD(PERIOD), .INDEX_WIDTH(WIDTH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .spin_enable(spin_enable), .fault_clear(fault_clear),
        .st506_drv_sel_n(drv_sel_n), .st506_head_sel_n(head_sel_n), .st506_step_n(step_n),
        .st506_dir_n(dir_n), .st506_write_gate_n(write_gate_n),
        .st506_seek_complete_n(seek_complete_n), .st506_track00_n(track00_n),
        .st506_write_fault_n(write_fault_n), .st506_index_n(index_n), .st506_ready_n(ready_n),
        .selected(selected), .cylinder(cylinder), .head(head), .write_active(write_active)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_seek_done(output int n);
        n = 0;
        while (seek_complete_n !== 1'b0 && n < 200) begin
            tick(1);
            n++;
        end
    endtask

    // One host step pulse; the expected cylinder is queued at the trailing edge and
    // compared when the DUT's cylinder output is due (4th clock edge).
    task automatic step_pulse(input logic d, input int gap, input bit chk_lat);
        int prev;
        int got;
        prev = exp_cyl;
        dir_n = d;
        step_n = 1'b0;
        tick(3);
        step_n = 1'b1;
        if (d == 1'b0) exp_cyl = (exp_cyl < int'(MAXC)) ? exp_cyl + 1 : exp_cyl;
        else           exp_cyl = (exp_cyl > 0) ? exp_cyl - 1 : 0;
        exp_q.push_back(exp_cyl);
        tick(3);
        if (chk_lat) begin
            checks++;
            if (seek_complete_n !== 1'b0 || int'(cylinder) != prev) begin
                errors++;
                $display("FAIL step_latency_early: seek_n=%b cyl=%0d want seek_n=0 cyl=%0d",
                         seek_complete_n, cylinder, prev);
            end
        end
        tick(1);
        got = exp_q.pop_front();
        checks++;
        if (int'(cylinder) != got || seek_complete_n !== 1'b1) begin
            errors++;
            $display("FAIL step_cylinder: cyl=%0d seek_n=%b want cyl=%0d seek_n=1",
                     cylinder, seek_complete_n, got);
        end
        tick(gap);
    endtask

    task automatic test_reset;
        tick(3);
        checks++;
        if ({seek_complete_n, track00_n, write_fault_n, index_n, ready_n} !== 5'b11111 ||
            selected !== 1'b0 || cylinder !== 10'd0 || head !== 4'd0 || write_active !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: n_outs=%b sel=%b cyl=%0d head=%0d wa=%b want 11111 0 0 0 0",
                     {seek_complete_n, track00_n, write_fault_n, index_n, ready_n},
                     selected, cylinder, head, write_active);
        end
        reset_n = 1'b1;
        tick(3);
    endtask

    task automatic test_spinup;
        int early;
        int n;
        early = 0;
        spin_enable = 1'b1;
        for (int i = 0; i < int'(SPINUP); i++) begin
            tick(1);
            if (ready_n !== 1'b1) early++;
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL spinup_ready_early: ready_n low for %0d cycles want 0", early);
        end
        n = 0;
        while (ready_n !== 1'b0 && n < 10) begin
            tick(1);
            n++;
        end
        checks++;
        if (ready_n !== 1'b0 || n > 4) begin
            errors++;
            $display("FAIL spinup_ready: ready_n=%b after %0d extra cycles want 0 within 4", ready_n, n);
        end
        checks++;
        if (seek_complete_n !== 1'b0 || track00_n !== 1'b0 || selected !== 1'b1) begin
            errors++;
            $display("FAIL spinup_status: seek_n=%b trk0_n=%b sel=%b want 0 0 1",
                     seek_complete_n, track00_n, selected);
        end
    endtask

    task automatic test_step;
        int n;
        step_pulse(1'b0, 16, 1'b1);
        for (int i = 0; i < 3; i++) step_pulse(1'b0, 16, 1'b0);
        step_pulse(1'b0, 0, 1'b0);
        checks++;
        if (track00_n !== 1'b1 || cylinder !== 10'd5) begin
            errors++;
            $display("FAIL step_in_five: cyl=%0d trk0_n=%b want 5 1", cylinder, track00_n);
        end
        wait_seek_done(n);
        checks++;
        if (n < 46 || n > 52) begin
            errors++;
            $display("FAIL settle_time: seek done after %0d cycles want 46..52", n);
        end
        for (int i = 0; i < 6; i++) step_pulse(1'b1, 16, 1'b0);
        wait_seek_done(n);
        checks++;
        if (cylinder !== 10'd0 || track00_n !== 1'b0 || seek_complete_n !== 1'b0) begin
            errors++;
            $display("FAIL step_out_saturate: cyl=%0d trk0_n=%b seek_n=%b want 0 0 0",
                     cylinder, track00_n, seek_complete_n);
        end
    endtask

    task automatic test_max_cyl;
        int n;
        for (int i = 0; i < 10; i++) step_pulse(1'b0, 16, 1'b0);
        wait_seek_done(n);
        checks++;
        if (cylinder !== 10'(MAXC) || track00_n !== 1'b1 || seek_complete_n !== 1'b0) begin
            errors++;
            $display("FAIL step_in_saturate: cyl=%0d trk0_n=%b seek_n=%b want %0d 1 0",
                     cylinder, track00_n, seek_complete_n, MAXC);
        end
    endtask

    task automatic test_index;
        int n;
        int lw;
        int per;
        int lows;
        n = 0;
        while (index_n !== 1'b1 && n < 500) begin tick(1); n++; end
        while (index_n !== 1'b0 && n < 500) begin tick(1); n++; end
        checks++;
        if (index_n !== 1'b0) begin
            errors++;
            $display("FAIL index_seen: index_n=%b want 0 within 500 cycles", index_n);
        end
        lw = 0;
        while (index_n === 1'b0 && lw < 500) begin tick(1); lw++; end
        per = lw;
        while (index_n !== 1'b0 && per < 500) begin tick(1); per++; end
        checks++;
        if (lw != int'(WIDTH)) begin
            errors++;
            $display("FAIL index_width: %0d want %0d", lw, WIDTH);
        end
        checks++;
        if (per != int'(PERIOD)) begin
            errors++;
            $display("FAIL index_period: %0d want %0d", per, PERIOD);
        end
        drv_sel_n = 4'b1111;
        tick(3);
        lows = 0;
        for (int i = 0; i < 250; i++) begin
            if ({seek_complete_n, track00_n, write_fault_n, index_n, ready_n} !== 5'b11111) lows++;
            tick(1);
        end
        checks++;
        if (lows != 0 || selected !== 1'b0 || cylinder !== 10'(exp_cyl)) begin
            errors++;
            $display("FAIL deselect: active cycles=%0d sel=%b cyl=%0d want 0 0 %0d",
                     lows, selected, cylinder, exp_cyl);
        end
    endtask

    task automatic test_write_fault;
        drv_sel_n = 4'b1101;
        head_sel_n = ~4'd2;
        tick(3);
        write_gate_n = 1'b0;
        tick(4);
        checks++;
        if (write_active !== 1'b1 || write_fault_n !== 1'b1 || head !== 4'd2) begin
            errors++;
            $display("FAIL write_ok: wa=%b wf_n=%b head=%0d want 1 1 2", write_active, write_fault_n, head);
        end
        head_sel_n = ~4'd5;
        tick(4);
        checks++;
        if (write_active !== 1'b0 || write_fault_n !== 1'b0 || head !== 4'd5) begin
            errors++;
            $display("FAIL write_bad_head: wa=%b wf_n=%b head=%0d want 0 0 5", write_active, write_fault_n, head);
        end
        write_gate_n = 1'b1;
        head_sel_n = ~4'd0;
        tick(4);
        checks++;
        if (write_fault_n !== 1'b0) begin
            errors++;
            $display("FAIL fault_held: wf_n=%b want 0", write_fault_n);
        end
        fault_clear = 1'b1;
        tick(1);
        fault_clear = 1'b0;
        tick(2);
        checks++;
        if (write_fault_n !== 1'b1 || write_active !== 1'b0) begin
            errors++;
            $display("FAIL fault_clear: wf_n=%b wa=%b want 1 0", write_fault_n, write_active);
        end
    endtask

    task automatic test_spin_loss_and_reset;
        int lows;
        int n;
        step_pulse(1'b1, 5, 1'b0);
        spin_enable = 1'b0;
        tick(2);
        checks++;
        if (ready_n !== 1'b1 || seek_complete_n !== 1'b1 || track00_n !== 1'b1) begin
            errors++;
            $display("FAIL spin_loss: ready_n=%b seek_n=%b trk0_n=%b want 1 1 1",
                     ready_n, seek_complete_n, track00_n);
        end
        lows = 0;
        for (int i = 0; i < 300; i++) begin
            if (index_n !== 1'b1) lows++;
            tick(1);
        end
        checks++;
        if (lows != 0 || cylinder !== 10'(exp_cyl)) begin
            errors++;
            $display("FAIL spin_loss_index: index low %0d cyc cyl=%0d want 0 %0d", lows, cylinder, exp_cyl);
        end
        spin_enable = 1'b1;
        n = 0;
        while (ready_n !== 1'b0 && n < 300) begin tick(1); n++; end
        checks++;
        if (ready_n !== 1'b0) begin
            errors++;
            $display("FAIL respin_ready: ready_n=%b want 0", ready_n);
        end
        step_pulse(1'b1, 5, 1'b0);
        checks++;
        if (seek_complete_n !== 1'b1) begin
            errors++;
            $display("FAIL mid_seek: seek_n=%b want 1", seek_complete_n);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({seek_complete_n, track00_n, write_fault_n, index_n, ready_n} !== 5'b11111 ||
            cylinder !== 10'd0) begin
            errors++;
            $display("FAIL reset_mid_seek: n_outs=%b cyl=%0d want 11111 0",
                     {seek_complete_n, track00_n, write_fault_n, index_n, ready_n}, cylinder);
        end
        tick(2);
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_spinup();
        test_step();
        test_max_cyl();
        test_index();
        test_write_fault();
        test_spin_loss_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
